// File: rtl/imem_load_controller.sv
// imem_load_controller
//   Arbitrates a byte-addressed instruction store between the core's fetch
//   path and a byte-stream program loader such as a UART bootloader.
//   - RUN: fetches pass through. An illegal fetch address returns NOP_INST
//     and raises fetch_fault.
//   - LOAD: loader bytes are written into the store and the core is stalled.
//   - FLUSH: the final write commits. A pc_restart pulse follows.
//
// Ports
//   clk, reset          system clock, asynchronous active-low reset
//   load_start          one-cycle request to (re)start an image load
//   load_valid/data/last, load_ready   loader byte handshake
//   mem_we/waddr/wdata  registered byte write port into the store
//   mem_rdata           combinational 32-bit read of the store at fetch_addr
//   fetch_addr/inst/fault               core fetch path
//   cpu_stall, pc_restart               core control
//   load_count, load_error              status of current or most recent load
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | core owns the store; fetches pass through; idle until load_start
// LOAD  | loader bytes are written at ascending addresses; core stalled
// FLUSH | one cycle for the last write to commit; core still stalled
module imem_load_controller #(
  parameter int          MEM_BYTES = 96,
  parameter int          ADDR_W    = 7,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic [63:0]       fetch_addr,
  output logic [31:0]       fetch_inst,
  output logic              fetch_fault,
  output logic              cpu_stall,
  output logic              pc_restart,
  output logic [ADDR_W:0]   load_count,
  output logic              load_error
);

  typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_FLUSH} state_t;

  localparam logic [ADDR_W:0] MEM_BYTES_C = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [ADDR_W:0] CNT_ONE     = (ADDR_W+1)'(1);
  localparam logic [63:0]     LAST_WORD   = 64'(MEM_BYTES - 4);

  state_t              state_q, state_d;
  // The write pointer and the byte count advance together, so one register
  // serves as both.
  logic [ADDR_W:0]     wptr_q, wptr_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                restart_q, restart_d;
  logic                accept;
  logic                legal;

  // A beat offered in the same cycle as load_start is refused. The restart
  // wins, so that byte never lands at a stale address.
  assign load_ready = (state_q == ST_LOAD) && !load_start;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    err_d     = err_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    restart_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (load_start) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          wptr_d = '0;
          err_d  = 1'b0;
        end else if (accept) begin
          if (wptr_q < MEM_BYTES_C) begin
            we_d    = 1'b1;
            waddr_d = wptr_q[ADDR_W-1:0];
            wdata_d = load_data;
            wptr_d  = wptr_q + CNT_ONE;
          end else begin
            // The store is full. Keep draining the loader, but flag the image.
            err_d = 1'b1;
          end
          if (load_last) begin
            state_d = ST_FLUSH;
            if (wptr_d[1:0] != 2'b00) err_d = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        state_d   = ST_RUN;
        restart_d = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      wptr_q    <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      err_q     <= err_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      restart_q <= restart_d;
    end
  end

  assign mem_we     = we_q;
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wdata_q;
  assign load_count = wptr_q;
  assign load_error = err_q;
  assign pc_restart = restart_q;
  assign cpu_stall  = (state_q != ST_RUN);

  // Compare all 64 address bits so that an aliased high PC still faults.
  always_comb begin
    legal       = (fetch_addr[1:0] == 2'b00) && (fetch_addr <= LAST_WORD);
    fetch_inst  = NOP_INST;
    fetch_fault = 1'b0;
    if (state_q == ST_RUN) begin
      if (legal) fetch_inst  = mem_rdata;
      else       fetch_fault = 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_load_controller.sv
module tb_imem_load_controller;

  localparam int MEMB = 96;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int M_RUN = 0, M_LOAD = 1, M_FLUSH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [7:0]  load_data = 8'h00;
  logic        load_ready, mem_we, fetch_fault, cpu_stall, pc_restart, load_error;
  logic [6:0]  mem_waddr;
  logic [7:0]  mem_wdata;
  logic [31:0] mem_rdata, fetch_inst;
  logic [63:0] fetch_addr = 64'd0;
  logic [7:0]  load_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Store: preloaded from init_img, afterwards written only by the DUT.
  logic [7:0] store    [MEMB];
  logic [7:0] init_img [MEMB];
  logic       init_done = 1'b0;

  // Reference model state.
  logic [7:0] m_img [MEMB];
  int         m_mode = M_RUN;
  int         m_cnt  = 0;
  bit         m_err  = 0;
  bit         p_we   = 0;
  int         p_addr = 0;
  logic [7:0] p_data = 8'h00;

  imem_load_controller dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fetch_addr(fetch_addr), .fetch_inst(fetch_inst),
    .fetch_fault(fetch_fault), .cpu_stall(cpu_stall), .pc_restart(pc_restart),
    .load_count(load_count), .load_error(load_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < MEMB; i++) store[i] <= init_img[i];
    end else if (mem_we) begin
      store[int'(mem_waddr)] <= mem_wdata;
    end
  end

  always_comb begin
    mem_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (int'(fetch_addr[6:0]) + i < MEMB)
        mem_rdata[8*i +: 8] = store[int'(fetch_addr[6:0]) + i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_fetch();
    bit          legal;
    logic [31:0] e_inst;
    bit          e_fault;
    int          a;
    legal = (fetch_addr % 4 == 0) && (fetch_addr <= 64'(MEMB - 4));
    e_inst = NOP;
    e_fault = 0;
    if (m_mode == M_RUN) begin
      if (legal) begin
        a = int'(fetch_addr[6:0]);
        e_inst = {m_img[a+3], m_img[a+2], m_img[a+1], m_img[a]};
      end else begin
        e_fault = 1;
      end
    end
    chk("fetch_inst", 64'(fetch_inst), 64'(e_inst));
    chk("fetch_fault", 64'(fetch_fault), 64'(e_fault));
  endtask

  // One clock cycle: drive inputs, check the combinational outputs, advance
  // the model, cross the edge, then check the registered outputs.
  task automatic cycle(input bit s, input bit v, input logic [7:0] d, input bit l);
    bit         n_we, n_rst, rdy;
    int         n_addr;
    logic [7:0] n_data;
    load_start = s; load_valid = v; load_data = d; load_last = l;
    #1;
    rdy = (m_mode == M_LOAD) && !s;
    chk("load_ready", 64'(load_ready), 64'(rdy));
    chk("cpu_stall", 64'(cpu_stall), 64'(m_mode != M_RUN));
    check_fetch();
    if (p_we) m_img[p_addr] = p_data;
    n_we = 0; n_rst = 0; n_addr = 0; n_data = 8'h00;
    case (m_mode)
      M_RUN: if (s) begin m_mode = M_LOAD; m_cnt = 0; m_err = 0; end
      M_LOAD: begin
        if (s) begin
          m_cnt = 0; m_err = 0;
        end else if (v) begin
          if (m_cnt < MEMB) begin
            n_we = 1; n_addr = m_cnt; n_data = d; m_cnt++;
          end else begin
            m_err = 1;
          end
          if (l) begin
            if (m_cnt % 4 != 0) m_err = 1;
            m_mode = M_FLUSH;
          end
        end
      end
      default: begin m_mode = M_RUN; n_rst = 1; end
    endcase
    @(posedge clk); #1;
    chk("mem_we", 64'(mem_we), 64'(n_we));
    if (n_we) begin
      chk("mem_waddr", 64'(mem_waddr), 64'(n_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(n_data));
    end
    chk("load_count", 64'(load_count), 64'(m_cnt));
    chk("load_error", 64'(load_error), 64'(m_err));
    chk("pc_restart", 64'(pc_restart), 64'(n_rst));
    p_we = n_we; p_addr = n_addr; p_data = n_data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 0);
  endtask

  logic [7:0] prog [8];

  initial begin
    int len, remaining, did_restart;
    bit s, v;
    prog[0] = 8'h13; prog[1] = 8'h03; prog[2] = 8'h10; prog[3] = 8'h00;
    prog[4] = 8'h93; prog[5] = 8'h03; prog[6] = 8'h40; prog[7] = 8'h00;
    for (int i = 0; i < MEMB; i++) begin
      init_img[i] = 8'($urandom);
      m_img[i] = init_img[i];
    end

    // Reset values while reset is held low.
    @(posedge clk); #1;
    init_done = 1'b1;
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_waddr", 64'(mem_waddr), 64'd0);
    chk("rst_load_count", 64'(load_count), 64'd0);
    chk("rst_cpu_stall", 64'(cpu_stall), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Legal and illegal fetches in RUN.
    fetch_addr = 64'd0;  idle(1);
    fetch_addr = 64'd4;  idle(1);
    fetch_addr = 64'd92; idle(1);
    fetch_addr = 64'd2;  idle(1);
    fetch_addr = 64'd96; idle(1);
    fetch_addr = 64'h1_0000_0000; idle(1);
    chk("fault_hi_addr", 64'(fetch_fault), 64'd1);

    // Directed 8-byte image, back-to-back.
    fetch_addr = 64'd0;
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, prog[i], i == 7);
    chk("cnt8", 64'(load_count), 64'd8);
    idle(3);
    chk("img_word0", 64'(fetch_inst), 64'h0010_0313);
    fetch_addr = 64'd4; idle(1);
    chk("img_word1", 64'(fetch_inst), 64'h0040_0393);

    // 100 bytes into a 96-byte store.
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 100; i++) cycle(0, 1, 8'($urandom), i == 99);
    chk("cnt_ovf", 64'(load_count), 64'd96);
    chk("err_ovf", 64'(load_error), 64'd1);
    idle(3);

    // 6-byte image: a length that is not a multiple of 4.
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 8'($urandom), i == 5);
    chk("err6", 64'(load_error), 64'd1);
    // FLUSH, then load_start on the cycle where pc_restart is high.
    idle(1);
    cycle(1, 0, 8'h00, 0);
    // Restart mid-load while a 4th beat is offered.
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'($urandom), 0);
    cycle(1, 1, 8'h5a, 0);
    chk("restart_cnt", 64'(load_count), 64'd0);
    cycle(0, 1, 8'ha5, 0);
    chk("restart_addr0", 64'(mem_waddr), 64'd0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'($urandom), i == 2);
    idle(3);

    // Asynchronous reset in the middle of a load.
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'($urandom), 0);
    load_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("arst_mem_we", 64'(mem_we), 64'd0);
    chk("arst_mem_waddr", 64'(mem_waddr), 64'd0);
    chk("arst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("arst_load_count", 64'(load_count), 64'd0);
    chk("arst_load_error", 64'(load_error), 64'd0);
    chk("arst_pc_restart", 64'(pc_restart), 64'd0);
    chk("arst_cpu_stall", 64'(cpu_stall), 64'd0);
    chk("arst_load_ready", 64'(load_ready), 64'd0);
    m_mode = M_RUN; m_cnt = 0; m_err = 0; p_we = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);

    // Randomised loads with gaps and an occasional restart.
    for (int n = 0; n < 5; n++) begin
      len = $urandom_range(1, 110);
      remaining = len;
      did_restart = 0;
      fetch_addr = 64'($urandom_range(0, 23) * 4);
      cycle(1, 0, 8'h00, 0);
      while (remaining > 0) begin
        v = ($urandom_range(0, 3) != 0);
        s = (did_restart == 0) && ($urandom_range(0, 49) == 0);
        if (s) begin
          did_restart = 1;
          remaining = len;
        end
        cycle(s, v, 8'($urandom), v && !s && remaining == 1);
        if (v && !s) remaining--;
      end
      idle(2);
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(0, 3))
          0: fetch_addr = 64'($urandom_range(0, 31) * 4);
          1: fetch_addr = 64'($urandom_range(0, 95));
          2: fetch_addr = {32'($urandom_range(1, 255)), 32'($urandom_range(0, 23) * 4)};
          default: fetch_addr = 64'($urandom_range(0, 23) * 4);
        endcase
        idle(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_load_controller.md
Name: imem_load_controller

Overview:
Sequences the byte-addressed instruction store between two users: the core's fetch path and a byte-stream program loader (e.g. a UART bootloader). The block has three modes:
- LOAD: it streams loader bytes into the store through its byte write port and holds the core stalled.
- FLUSH: it commits the final write.
- RUN: it passes fetches through, substitutes a NOP for illegal fetch addresses and pulses a PC restart once after a new image is loaded.

Parameters:
MEM_BYTES, 96, size of the instruction store in bytes (multiple of 4).
ADDR_W, 7, width of the store byte address; must satisfy 2^ADDR_W >= MEM_BYTES.
NOP_INST, 32'h00000013, instruction returned on stalled or faulting fetch (addi x0,x0,0).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
load_start  input  1  one-cycle request to begin a new image load.
load_valid  input  1  loader byte valid.
load_data  input  8  loader byte, stored little-endian at ascending addresses.
load_last  input  1  marks the final byte of the image; qualified by the load_valid/load_ready handshake.
load_ready  output  1  controller accepts the byte this cycle.
mem_we  output  1  store byte write enable.
mem_waddr  output  ADDR_W  store byte write address.
mem_wdata  output  8  store byte write data.
mem_rdata  input  32  store combinational read of bytes {A+3,A+2,A+1,A}.
fetch_addr  input  64  core PC.
fetch_inst  output  32  instruction presented to the core.
fetch_fault  output  1  illegal fetch address while in RUN.
cpu_stall  output  1  core must hold its PC.
pc_restart  output  1  one-cycle pulse: core reloads PC to 0.
load_count  output  ADDR_W+1  bytes written by the current or most recent load.
load_error  output  1  sticky error for the current or most recent load.

Behaviour:
- Reset is asynchronous and active-low; while reset is low, every register holds its reset value.
  - state = RUN; the store's preloaded contents are valid.
  - mem_we = 0, mem_waddr = 0, mem_wdata = 0.
  - load_count = 0, load_error = 0, pc_restart = 0.
  - The write pointer wptr = 0.
- Reset taken mid-load abandons the load. State returns to RUN; the partial image remains in the store.
- FSM states: RUN, LOAD, FLUSH.
  - RUN -> LOAD on load_start. On that edge: wptr <= 0, load_count <= 0, load_error <= 0.
  - LOAD -> LOAD on load_start. The load restarts with the same clears, and any beat offered that cycle is not accepted.
  - LOAD -> FLUSH when a beat with load_last is accepted.
  - FLUSH -> RUN after exactly one cycle. pc_restart = 1 during the first RUN cycle only.
  - In FLUSH, load_start is ignored. In RUN, load_start is honoured on the same edge on which pc_restart is high.
- load_ready = (state == LOAD) && !load_start. This is combinational from registered state.
- Accepted beat (load_valid && load_ready):
  - If wptr < MEM_BYTES:
    - next cycle mem_we = 1, mem_waddr = wptr, mem_wdata = load_data (1-cycle registered write latency);
    - wptr and load_count increment.
  - If wptr >= MEM_BYTES: the beat is dropped, load_error <= 1 and mem_we stays 0. load_ready stays high so the loader can drain.
  - mem_we is 0 in every cycle not following an accepted, in-range beat.
- On accepted load_last, load_error <= 1 if the resulting byte count is not a multiple of 4. load_error is sticky until the next load_start.
- cpu_stall = 1 in LOAD and FLUSH, 0 in RUN.
- Fetch path (combinational):
  - legal = fetch_addr[1:0] == 0 && fetch_addr <= MEM_BYTES-4; the compare uses the full 64 bits.
  - In RUN and legal: fetch_inst = mem_rdata, fetch_fault = 0.
  - In RUN and not legal: fetch_inst = NOP_INST, fetch_fault = 1.
  - In LOAD or FLUSH: fetch_inst = NOP_INST, fetch_fault = 0.
- Back-to-back beats are accepted every cycle. A gap in load_valid inserts no write.

Test Plan:
- Release reset; fetch_addr = 0, 4, 92 -> fetch_inst = mem_rdata, fetch_fault = 0, cpu_stall = 0, load_ready = 0.
- Fetch addresses 2, 96 and 64'h1_0000_0000 -> fetch_inst = 32'h00000013, fetch_fault = 1.
- Load 8 bytes 0x13,0x03,0x10,0x00,0x93,0x03,0x40,0x00 back-to-back, last on byte 8:
  - mem_we pulses 8 consecutive cycles, one cycle after each accept, addresses 0..7;
  - load_count = 8, load_error = 0;
  - one FLUSH cycle, then a single pc_restart pulse;
  - cpu_stall high from the cycle after load_start through FLUSH.
- Load 100 bytes with MEM_BYTES = 96 -> exactly 96 writes, load_count = 96, load_error = 1, FSM still reaches RUN with a pc_restart pulse.
- Load 6 bytes, last on the 6th -> 6 writes, load_error = 1 (not a multiple of 4).
- Assert load_start after 3 beats while a 4th beat is offered in the same cycle -> 4th beat not accepted, load_count = 0. The next accepted byte writes address 0.
- Pull reset low in the middle of a load -> all outputs go to reset values immediately (asynchronous), state = RUN, cpu_stall = 0.
